// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared size/state encodings and lane-select helpers for wb_master32
package wb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] calc_sel(input logic [1:0] size, input logic [1:0] adr_lo);
    case (size)
      SZ_BYTE: calc_sel = 4'b0001 << adr_lo;
      SZ_HALF: calc_sel = adr_lo[1] ? 4'b1100 : 4'b0011;
      default: calc_sel = 4'b1111;
    endcase
  endfunction

  // Reserved size and unaligned half/word accesses never reach the bus.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] adr_lo);
    case (size)
      SZ_BYTE: is_legal = 1'b1;
      SZ_HALF: is_legal = (adr_lo[0] == 1'b0);
      SZ_WORD: is_legal = (adr_lo == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_lane_extract.sv
// rtl/wb_lane_extract.sv - right-justifies and zero-extends the addressed read lane
module wb_lane_extract
  import wb_pkg::*;
(
  input  logic [31:0] wb_dat_i,
  input  logic [1:0]  size,
  input  logic [1:0]  adr_lo,
  output logic [31:0] rdat
);

  // Pick the lane(s) named by size/offset and shift them down to bit 0.
  always_comb begin
    rdat = '0;
    case (size)
      SZ_BYTE: begin
        case (adr_lo)
          2'd0:    rdat = {24'h0, wb_dat_i[7:0]};
          2'd1:    rdat = {24'h0, wb_dat_i[15:8]};
          2'd2:    rdat = {24'h0, wb_dat_i[23:16]};
          default: rdat = {24'h0, wb_dat_i[31:24]};
        endcase
      end
      SZ_HALF: rdat = adr_lo[1] ? {16'h0, wb_dat_i[31:16]} : {16'h0, wb_dat_i[15:0]};
      default: rdat = wb_dat_i;
    endcase
  end

endmodule

// File: rtl/wb_master32.sv
// rtl/wb_master32.sv - 32-bit Wishbone classic initiator with alignment checks and watchdog
module wb_master32
  import wb_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_wdat,
  output logic [31:0] cpu_rdat,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  state_t              state;
  state_t              state_nxt;
  logic [TO_WIDTH-1:0] cnt;
  logic [1:0]          size_q;
  logic [1:0]          adr_lo_q;
  logic [31:0]         lane_rdat;
  logic [31:0]         wdat_rep;
  logic                req_legal;
  logic                timed_out;

  // Lane extraction works from the size/offset captured at acceptance.
  wb_lane_extract u_lane_extract (
    .wb_dat_i (wb_dat_i),
    .size     (size_q),
    .adr_lo   (adr_lo_q),
    .rdat     (lane_rdat)
  );

  // Request legality, watchdog expiry and write-data lane replication.
  always_comb begin
    req_legal = is_legal(cpu_size, cpu_adr[1:0]);
    timed_out = (TIMEOUT != 0) && (cnt == TO_WIDTH'(TIMEOUT - 1));
    case (cpu_size)
      SZ_BYTE: wdat_rep = {4{cpu_wdat[7:0]}};
      SZ_HALF: wdat_rep = {2{cpu_wdat[15:0]}};
      default: wdat_rep = cpu_wdat;
    endcase
  end

  // Next-state: ack takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cpu_req && req_legal) state_nxt = ST_BUS;
      ST_BUS: begin
        if (wb_ack_i)       state_nxt = ST_DONE;
        else if (timed_out) state_nxt = ST_IDLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Bus outputs, response pulses, watchdog counter and captured access shape.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      cpu_rdat <= '0;
      cpu_ack  <= 1'b0;
      cpu_err  <= 1'b0;
      cnt      <= '0;
      size_q   <= SZ_BYTE;
      adr_lo_q <= 2'b00;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            if (req_legal) begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= cpu_we;
              wb_adr_o <= {cpu_adr[31:2], 2'b00};
              wb_sel_o <= calc_sel(cpu_size, cpu_adr[1:0]);
              wb_dat_o <= wdat_rep;
              cnt      <= '0;
              size_q   <= cpu_size;
              adr_lo_q <= cpu_adr[1:0];
            end else begin
              cpu_err <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            cpu_ack  <= 1'b1;
            if (!wb_we_o) cpu_rdat <= lane_rdat;
          end else if (timed_out) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            cpu_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_wb_master32.sv
// tb/tb_wb_master32.sv - randomized self-checking bench for wb_master32
module tb_wb_master32;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_adr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_wdat;
  logic [31:0] cpu_rdat;
  logic        cpu_ack;
  logic        cpu_err;
  logic        cpu_busy;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rdat;

  always #5 clk = ~clk;

  wb_master32 #(.TIMEOUT(TO), .TO_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_adr  (cpu_adr),
    .cpu_size (cpu_size),
    .cpu_wdat (cpu_wdat),
    .cpu_rdat (cpu_rdat),
    .cpu_ack  (cpu_ack),
    .cpu_err  (cpu_err),
    .cpu_busy (cpu_busy),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int m_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic m_legal(input logic [1:0] size, input logic [1:0] lo);
    if (size == 2'd3) return 1'b0;
    return (int'(lo) % m_bytes(size)) == 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [1:0] lo);
    int mask;
    mask = ((1 << m_bytes(size)) - 1) << lo;
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdat(input logic [1:0] size, input logic [31:0] wdat);
    logic [31:0] r;
    int nb;
    nb = m_bytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdat[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdat(input logic [1:0] size, input logic [1:0] lo, input logic [31:0] rd);
    logic [31:0] s;
    int nb;
    nb = m_bytes(size);
    s = rd >> (8 * int'(lo));
    if (nb < 4) s = s & ((32'h1 << (8 * nb)) - 32'h1);
    return s;
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [1:0] size,
                         input logic [31:0] wdat, input int wait_cyc, input logic [31:0] slv_dat,
                         input bit no_ack);
    int lat;
    int cyc_cnt;
    bit done;
    @(negedge clk);
    wb_ack_i = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_adr  = adr;
    cpu_size = size;
    cpu_wdat = wdat;
    @(negedge clk);
    cpu_req  = 1'b0;
    cpu_we   = 1'($urandom);
    cpu_adr  = $urandom;
    cpu_size = 2'($urandom);
    cpu_wdat = $urandom;
    if (!m_legal(size, adr[1:0])) begin
      check("illegal_err", 32'(cpu_err), 32'd1);
      check("illegal_no_cyc", 32'(wb_cyc_o), 32'd0);
      check("illegal_no_ack", 32'(cpu_ack), 32'd0);
      check("illegal_busy", 32'(cpu_busy), 32'd0);
      @(negedge clk);
      check("illegal_err_clear", 32'(cpu_err), 32'd0);
      check("illegal_rdat", cpu_rdat, model_rdat);
      return;
    end
    check("issue_cyc", 32'(wb_cyc_o & wb_stb_o), 32'd1);
    check("issue_we", 32'(wb_we_o), 32'(we));
    check("issue_adr", wb_adr_o, {adr[31:2], 2'b00});
    check("issue_sel", 32'(wb_sel_o), 32'(m_sel(size, adr[1:0])));
    if (we) check("issue_dat", wb_dat_o, m_wdat(size, wdat));
    check("issue_busy", 32'(cpu_busy), 32'd1);
    lat = 1;
    cyc_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (wb_cyc_o) cyc_cnt++;
      wb_dat_i = $urandom;
      if (!no_ack && i == wait_cyc) begin
        wb_ack_i = 1'b1;
        wb_dat_i = slv_dat;
      end
      @(negedge clk);
      wb_ack_i = 1'b0;
      lat++;
      if (cpu_ack || cpu_err) done = 1'b1;
    end
    check("resp_within_bound", 32'(done), 32'd1);
    if (no_ack) begin
      check("to_err", 32'(cpu_err), 32'd1);
      check("to_no_ack", 32'(cpu_ack), 32'd0);
      check("to_cyc_cycles", 32'(cyc_cnt), 32'(TO));
    end else begin
      check("done_ack", 32'(cpu_ack), 32'd1);
      check("done_no_err", 32'(cpu_err), 32'd0);
      check("done_latency", 32'(lat), 32'(wait_cyc + 2));
      if (!we) model_rdat = m_rdat(size, adr[1:0], slv_dat);
    end
    check("end_cyc_low", 32'(wb_cyc_o | wb_stb_o), 32'd0);
    check("end_rdat", cpu_rdat, model_rdat);
    // A stray ack outside BUS must be ignored.
    wb_ack_i = 1'($urandom);
    @(negedge clk);
    wb_ack_i = 1'b0;
    check("idle_no_pulse", 32'({cpu_ack, cpu_err}), 32'd0);
    check("idle_cyc_low", 32'(wb_cyc_o), 32'd0);
    check("idle_not_busy", 32'(cpu_busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_we   = 1'b0;
    cpu_adr  = '0;
    cpu_size = '0;
    cpu_wdat = '0;
    wb_dat_i = '0;
    wb_ack_i = 1'b0;
    model_rdat = '0;
    repeat (2) @(negedge clk);
    check("rst_cyc", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_sel_dat", 32'(wb_sel_o) | wb_dat_o, 32'd0);
    check("rst_rdat", cpu_rdat, 32'd0);
    check("rst_pulses", 32'({cpu_ack, cpu_err, cpu_busy}), 32'd0);
    reset = 1'b0;

    run_txn(1'b0, 32'h0000_1004, 2'd2, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b1, 32'h0000_0203, 2'd0, 32'h0000_00A5, 1, 32'h0, 1'b0);
    run_txn(1'b0, 32'h0000_0012, 2'd1, 32'h0, 0, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 32'h0000_0001, 2'd2, 32'h0, 0, 32'h0, 1'b0);
    run_txn(1'b1, 32'h0000_0100, 2'd3, 32'h0, 0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h0000_0040, 2'd2, 32'h0, 0, 32'h0, 1'b1);
    run_txn(1'b0, 32'h0000_0043, 2'd0, 32'h0, 2, 32'hCAFE_F00D, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_txn(1'($urandom), $urandom, 2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, TO - 1), $urandom, ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a bus cycle.
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_adr  = 32'h0000_2000;
    cpu_size = 2'd2;
    @(negedge clk);
    cpu_req = 1'b0;
    check("mid_rst_in_bus", 32'(wb_cyc_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cyc_drop", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
    check("mid_rst_busy", 32'(cpu_busy), 32'd0);
    check("mid_rst_no_pulse", 32'({cpu_ack, cpu_err}), 32'd0);
    model_rdat = '0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("late_ack_no_pulse", 32'({cpu_ack, cpu_err}), 32'd0);
    check("late_ack_cyc", 32'(wb_cyc_o), 32'd0);
    check("late_ack_rdat", cpu_rdat, model_rdat);
    wb_ack_i = 1'b0;

    run_txn(1'b0, 32'h0000_3006, 2'd1, 32'h0, 1, 32'hA1B2_C3D4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
